// File: rtl/buyruk_onbellegi_pkg.sv
// rtl/buyruk_onbellegi_pkg.sv - shared state encoding, NOP constant and default line geometry
package buyruk_onbellegi_pkg;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        ISTEK  = 2'd1,
        DOLDUR = 2'd2,
        CEVAP  = 2'd3
    } durum_t;

    localparam logic [31:0] NOP_BUYRUK = 32'h0000_0013;

    localparam int VARSAYILAN_SATIR_SAYISI = 64;
    localparam int VARSAYILAN_SATIR_KELIME = 4;

    // Tag is whatever remains above byte, word-offset and index fields.
    function automatic int etiket_genisligi(input int satir_sayisi, input int satir_kelime);
        return 32 - 2 - $clog2(satir_sayisi) - $clog2(satir_kelime);
    endfunction

endpackage

// File: rtl/buyruk_onbellek_dizisi.sv
// rtl/buyruk_onbellek_dizisi.sv - tag/valid/data storage, one read port and one line-write port
module buyruk_onbellek_dizisi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI = VARSAYILAN_SATIR_SAYISI,
    parameter int SATIR_KELIME = VARSAYILAN_SATIR_KELIME,
    parameter int ETIKET_W     = etiket_genisligi(SATIR_SAYISI, SATIR_KELIME),
    parameter int IDX_W        = $clog2(SATIR_SAYISI)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [IDX_W-1:0]              oku_indeks_i,
    output logic                          oku_gecerli_o,
    output logic [ETIKET_W-1:0]           oku_etiket_o,
    output logic [SATIR_KELIME-1:0][31:0] oku_satir_o,
    input  logic                          yaz_en_i,
    input  logic [IDX_W-1:0]              yaz_indeks_i,
    input  logic [ETIKET_W-1:0]           yaz_etiket_i,
    input  logic [SATIR_KELIME-1:0][31:0] yaz_satir_i,
    input  logic                          temizle_i
);

    logic [SATIR_SAYISI-1:0]          r_gecerli;
    logic [ETIKET_W-1:0]              r_etiket [SATIR_SAYISI];
    logic [SATIR_KELIME-1:0][31:0]    r_veri   [SATIR_SAYISI];

    // Valid bits: cleared by reset or invalidate-all, set when a line is installed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_gecerli <= '0;
        end else if (temizle_i) begin
            r_gecerli <= '0;
        end else if (yaz_en_i) begin
            r_gecerli[yaz_indeks_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; a line only matters once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (yaz_en_i) begin
            r_etiket[yaz_indeks_i] <= yaz_etiket_i;
            r_veri[yaz_indeks_i]   <= yaz_satir_i;
        end
    end

    assign oku_gecerli_o = r_gecerli[oku_indeks_i];
    assign oku_etiket_o  = r_etiket[oku_indeks_i];
    assign oku_satir_o   = r_veri[oku_indeks_i];

endmodule

// File: rtl/buyruk_onbellegi.sv
// rtl/buyruk_onbellegi.sv - direct-mapped instruction cache; BUYRUK_ONBELLEK_SAYAC_EN adds hit/miss counters
module buyruk_onbellegi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI = VARSAYILAN_SATIR_SAYISI,
    parameter int SATIR_KELIME = VARSAYILAN_SATIR_KELIME
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] buyruk_adres_i,
    input  logic        ps_guncellendi_i,
    input  logic        bbellek_durdur_i,
    input  logic        iptal_i,
    input  logic        temizle_i,
    output logic [31:0] buyruk_o,
    output logic        buyruk_hazir_o,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_kabul_i,
    input  logic        bellek_veri_gecerli_i,
    input  logic [31:0] bellek_veri_i
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
    ,
    output logic [31:0] isabet_sayisi_o,
    output logic [31:0] iska_sayisi_o
`endif
);

    localparam int OFS_W      = $clog2(SATIR_KELIME);
    localparam int IDX_W      = $clog2(SATIR_SAYISI);
    localparam int ETIKET_W   = etiket_genisligi(SATIR_SAYISI, SATIR_KELIME);
    localparam int ETIKET_LSB = 2 + OFS_W + IDX_W;
    localparam logic [31:0] SATIR_MASKE = ~((32'd1 << (2 + OFS_W)) - 32'd1);
    localparam logic [OFS_W-1:0] SON_KELIME = OFS_W'(SATIR_KELIME - 1);

    durum_t                        r_durum;
    durum_t                        w_durum_sonraki;
    logic [31:0]                   r_adres;
    logic [31:0]                   r_buyruk;
    logic [31:0]                   r_bellek_adres;
    logic [OFS_W-1:0]              r_sayac;
    logic                          r_hazir;
    logic                          r_hazir_isabet;
    logic                          r_iptal;
    logic                          r_temizle_bekle;
    logic [SATIR_KELIME-1:0][31:0] r_tampon;
    logic [SATIR_KELIME-1:0][31:0] w_yaz_satir;
    logic [SATIR_KELIME-1:0][31:0] w_oku_satir;
    logic                          w_oku_gecerli;
    logic [ETIKET_W-1:0]           w_oku_etiket;
    logic [OFS_W-1:0]              w_ofs;
    logic [IDX_W-1:0]              w_idx;
    logic [ETIKET_W-1:0]           w_etiket;
    logic                          w_kabul;
    logic                          w_isabet;
    logic                          w_son_vurus;
    logic                          w_yaz;
    logic                          w_temizle;
    logic                          w_hazir;
    logic                          w_unused;

    assign w_ofs    = buyruk_adres_i[2 +: OFS_W];
    assign w_idx    = buyruk_adres_i[2 + OFS_W +: IDX_W];
    assign w_etiket = buyruk_adres_i[ETIKET_LSB +: ETIKET_W];
    assign w_unused = ^{buyruk_adres_i[1:0], r_adres[1:0]};

    // No acceptance while a response pulse is out (keeps pulses one cycle apart)
    // or while a deferred flush still has to be applied.
    assign w_kabul = (r_durum == BOSTA) && ps_guncellendi_i && !bbellek_durdur_i &&
                     !iptal_i && !temizle_i && !r_hazir && !r_temizle_bekle;
    assign w_isabet    = w_oku_gecerli && (w_oku_etiket == w_etiket);
    assign w_son_vurus = (r_durum == DOLDUR) && bellek_veri_gecerli_i && (r_sayac == SON_KELIME);
    assign w_yaz       = w_son_vurus;
    assign w_temizle   = (r_durum == BOSTA) && (temizle_i || r_temizle_bekle);
    assign w_hazir     = r_hazir && !iptal_i;

    assign buyruk_o       = r_buyruk;
    assign buyruk_hazir_o = w_hazir;
    assign bellek_istek_o = (r_durum == ISTEK);
    assign bellek_adres_o = r_bellek_adres;

    buyruk_onbellek_dizisi #(
        .SATIR_SAYISI (SATIR_SAYISI),
        .SATIR_KELIME (SATIR_KELIME),
        .ETIKET_W     (ETIKET_W),
        .IDX_W        (IDX_W)
    ) u_dizi (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .oku_indeks_i  (w_idx),
        .oku_gecerli_o (w_oku_gecerli),
        .oku_etiket_o  (w_oku_etiket),
        .oku_satir_o   (w_oku_satir),
        .yaz_en_i      (w_yaz),
        .yaz_indeks_i  (r_adres[2 + OFS_W +: IDX_W]),
        .yaz_etiket_i  (r_adres[ETIKET_LSB +: ETIKET_W]),
        .yaz_satir_i   (w_yaz_satir),
        .temizle_i     (w_temizle)
    );

    // Line written to the array: buffered beats with the final beat merged in.
    always_comb begin
        w_yaz_satir          = r_tampon;
        w_yaz_satir[r_sayac] = bellek_veri_i;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_durum_sonraki;
        end
    end

    // Next-state logic.
    always_comb begin
        w_durum_sonraki = r_durum;
        case (r_durum)
            BOSTA:   if (w_kabul && !w_isabet) w_durum_sonraki = ISTEK;
            ISTEK:   if (bellek_kabul_i)       w_durum_sonraki = DOLDUR;
            DOLDUR:  if (w_son_vurus)          w_durum_sonraki = CEVAP;
            CEVAP:                             w_durum_sonraki = BOSTA;
            default:                           w_durum_sonraki = BOSTA;
        endcase
    end

    // Request capture, beat counting, response pulse, squash and deferred-flush flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_adres         <= '0;
            r_buyruk        <= NOP_BUYRUK;
            r_bellek_adres  <= '0;
            r_sayac         <= '0;
            r_hazir         <= 1'b0;
            r_hazir_isabet  <= 1'b0;
            r_iptal         <= 1'b0;
            r_temizle_bekle <= 1'b0;
        end else begin
            r_hazir <= 1'b0;
            if (w_kabul) begin
                if (w_isabet) begin
                    r_hazir        <= 1'b1;
                    r_hazir_isabet <= 1'b1;
                    r_buyruk       <= w_oku_satir[w_ofs];
                end else begin
                    r_adres        <= buyruk_adres_i;
                    r_bellek_adres <= buyruk_adres_i & SATIR_MASKE;
                    r_iptal        <= 1'b0;
                end
            end
            if ((r_durum == DOLDUR) && bellek_veri_gecerli_i) begin
                r_sayac <= r_sayac + 1'b1;
            end
            if (w_son_vurus && !r_iptal && !iptal_i) begin
                r_hazir        <= 1'b1;
                r_hazir_isabet <= 1'b0;
                r_buyruk       <= w_yaz_satir[r_adres[2 +: OFS_W]];
            end
            if ((r_durum != BOSTA) && iptal_i) begin
                r_iptal <= 1'b1;
            end
            if (r_durum != BOSTA) begin
                if (temizle_i) begin
                    r_temizle_bekle <= 1'b1;
                end
            end else begin
                r_temizle_bekle <= 1'b0;
            end
        end
    end

    // Fill buffer collects beats in arrival order.
    always_ff @(posedge clk_i) begin
        if ((r_durum == DOLDUR) && bellek_veri_gecerli_i) begin
            r_tampon[r_sayac] <= bellek_veri_i;
        end
    end

`ifdef BUYRUK_ONBELLEK_SAYAC_EN
    // Hit/miss counters advance only when a response is actually delivered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            isabet_sayisi_o <= '0;
            iska_sayisi_o   <= '0;
        end else if (w_hazir) begin
            if (r_hazir_isabet) begin
                isabet_sayisi_o <= isabet_sayisi_o + 32'd1;
            end else begin
                iska_sayisi_o <= iska_sayisi_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// tb/tb_buyruk_onbellegi.sv - directed and randomized bench for buyruk_onbellegi
module tb_buyruk_onbellegi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adres = '0;
    logic        ps = 1'b0;
    logic        durdur = 1'b0;
    logic        iptal = 1'b0;
    logic        temizle = 1'b0;
    logic [31:0] buyruk_o;
    logic        buyruk_hazir_o;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        kabul = 1'b0;
    logic        veri_gecerli = 1'b0;
    logic [31:0] veri = '0;
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
    logic [31:0] isabet_sayisi_o;
    logic [31:0] iska_sayisi_o;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    bit          m_gecerli [64];
    logic [21:0] m_etiket  [64];
    logic [31:0] m_son = 32'h0000_0013;

    buyruk_onbellegi dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .buyruk_adres_i        (adres),
        .ps_guncellendi_i      (ps),
        .bbellek_durdur_i      (durdur),
        .iptal_i               (iptal),
        .temizle_i             (temizle),
        .buyruk_o              (buyruk_o),
        .buyruk_hazir_o        (buyruk_hazir_o),
        .bellek_istek_o        (bellek_istek_o),
        .bellek_adres_o        (bellek_adres_o),
        .bellek_kabul_i        (kabul),
        .bellek_veri_gecerli_i (veri_gecerli),
        .bellek_veri_i         (veri)
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
        ,
        .isabet_sayisi_o       (isabet_sayisi_o),
        .iska_sayisi_o         (iska_sayisi_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] taban, input int w);
        if (taban == 32'h0000_0100) return 32'hA0 + 32'(w);
        return taban ^ (32'(w) << 2) ^ 32'hC0DE_0000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_gecerli[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hazir"}, buyruk_hazir_o, 32'd0);
        check({tag, "_istek"}, bellek_istek_o, 32'd0);
        check({tag, "_buyruk"}, buyruk_o, 32'h0000_0013);
        check({tag, "_adres"}, bellek_adres_o, 32'd0);
    endtask

    // One fetch: acts as fetch stage and memory, compares against the line model.
    task automatic do_fetch(input logic [31:0] a, input int iptal_vurus,
                            input bit temizle_istek, input int reset_vurus);
        logic [31:0] taban;
        logic [21:0] etk;
        int          idx;
        bit          beklenen_isabet;
        bit          goruldu;
        bit          ezildi;
        int          bekle;
        int          gecikme;
        logic [31:0] beklenen_kelime;
        taban = a & 32'hFFFF_FFF0;
        idx   = int'(a[9:4]);
        etk   = a[31:10];
        beklenen_isabet = m_gecerli[idx] && (m_etiket[idx] == etk);
        beklenen_kelime = mem_word(taban, int'(a[3:2]));
        ezildi  = 1'b0;
        goruldu = 1'b0;
        bekle   = 0;
        adres   = a;
        ps      = 1'b1;
        while (!goruldu && bekle < 8) begin
            @(negedge clk);
            if (buyruk_hazir_o || bellek_istek_o) goruldu = 1'b1;
            else bekle++;
        end
        ps = 1'b0;
        check("kabul", 32'(goruldu), 32'd1);
        if (!goruldu) return;
        check("isabet_turu", 32'(buyruk_hazir_o), 32'(beklenen_isabet));
        if (beklenen_isabet) begin
            check("isabet_gecikme", 32'(bekle), 32'd0);
            check("isabet_veri", buyruk_o, beklenen_kelime);
            check("isabet_istek_yok", 32'(bellek_istek_o), 32'd0);
            m_son = beklenen_kelime;
            @(negedge clk);
            check("tek_darbe", 32'(buyruk_hazir_o), 32'd0);
            return;
        end
        check("dolum_adres", bellek_adres_o, taban);
        gecikme = $urandom_range(0, 2);
        if (temizle_istek && gecikme == 0) gecikme = 1;
        for (int i = 0; i < gecikme; i++) begin
            temizle = temizle_istek && (i == 0);
            @(negedge clk);
            temizle = 1'b0;
            check("istek_sabit", 32'(bellek_istek_o), 32'd1);
            check("adres_sabit", bellek_adres_o, taban);
        end
        kabul = 1'b1;
        @(negedge clk);
        kabul = 1'b0;
        check("istek_dustu", 32'(bellek_istek_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            veri_gecerli = 1'b1;
            veri = mem_word(taban, b);
            if (b == iptal_vurus) begin
                iptal  = 1'b1;
                ezildi = 1'b1;
            end
            if (b == reset_vurus) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("dolum_reset");
                @(negedge clk);
                rst = 1'b1;
                veri_gecerli = 1'b0;
                iptal = 1'b0;
                model_clear();
                m_son = 32'h0000_0013;
                return;
            end
            @(negedge clk);
            veri_gecerli = 1'b0;
            iptal = 1'b0;
        end
        check("cevap_darbe", 32'(buyruk_hazir_o), 32'(!ezildi));
        if (!ezildi) m_son = beklenen_kelime;
        check("cevap_veri", buyruk_o, m_son);
        @(negedge clk);
        check("cevap_sonrasi", 32'(buyruk_hazir_o), 32'd0);
        m_gecerli[idx] = 1'b1;
        m_etiket[idx]  = etk;
        if (temizle_istek) model_clear();
    endtask

    initial begin
        logic [31:0] ra;
        int          ri;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        do_fetch(32'h0000_0100, -1, 1'b0, -1);
        do_fetch(32'h0000_0104, -1, 1'b0, -1);
        do_fetch(32'h0000_0500, -1, 1'b0, -1);
        do_fetch(32'h0000_0100, -1, 1'b0, -1);
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
        check("isabet_sayisi", isabet_sayisi_o, 32'd1);
        check("iska_sayisi", iska_sayisi_o, 32'd3);
`endif
        do_fetch(32'h0000_0500, -1, 1'b0, -1);
        do_fetch(32'h0000_0100, 2, 1'b0, -1);
        do_fetch(32'h0000_0100, -1, 1'b0, -1);
        do_fetch(32'h0000_2000, -1, 1'b1, -1);
        do_fetch(32'h0000_0100, -1, 1'b0, -1);
        do_fetch(32'h0000_0300, -1, 1'b0, 1);
        do_fetch(32'h0000_0100, -1, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                 (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            ri = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_fetch(ra, ri, ($urandom_range(0, 9) == 0), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/buyruk_onbellegi.md
BUYRUK_ONBELLEGI -- requirements
Module: buyruk_onbellegi

Interface
REQ-001 The block SHALL have parameter SATIR_SAYISI, default 64, meaning number of direct-mapped lines (power of two).
REQ-002 The block SHALL have parameter SATIR_KELIME, default 4, meaning 32-bit words per line (power of two).
REQ-003 The block SHALL use one clock and an asynchronous active-low reset; ports clk_i and rst_i come first in the port list.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- buyruk_adres_i  in  32  fetch address from the fetch stage
- ps_guncellendi_i  in  1  fetch request valid
- bbellek_durdur_i  in  1  stall from the fetch stage
- iptal_i  in  1  branch-mispredict/jal squash
- temizle_i  in  1  fence.i invalidate-all
- buyruk_o  out  32  instruction word
- buyruk_hazir_o  out  1  one-cycle data-valid pulse
- bellek_istek_o  out  1  line-fill request
- bellek_adres_o  out  32  line-aligned fill address
- bellek_kabul_i  in  1  memory accepted the request
- bellek_veri_gecerli_i  in  1  fill beat valid
- bellek_veri_i  in  32  fill beat data

Function
REQ-005 Address split SHALL be: bits [1:0] ignored (aligned word returned); word offset log2(SATIR_KELIME) bits; index log2(SATIR_SAYISI) bits; tag the remaining upper bits.
REQ-006 A request SHALL be accepted only in state BOSTA with ps_guncellendi_i=1, bbellek_durdur_i=0, iptal_i=0 and temizle_i=0.
REQ-007 On a hit, buyruk_o SHALL carry the addressed word and buyruk_hazir_o SHALL pulse exactly one cycle after acceptance.
REQ-008 FSM states SHALL be BOSTA, ISTEK, DOLDUR and CEVAP.
- BOSTA to ISTEK on an accepted miss.
- ISTEK to DOLDUR on bellek_kabul_i.
- DOLDUR to CEVAP after SATIR_KELIME beats.
- CEVAP to BOSTA after one cycle.
REQ-009 In ISTEK, bellek_istek_o SHALL be 1 with a stable bellek_adres_o (line base, low offset bits zero) until the cycle in which bellek_kabul_i=1 inclusive.
REQ-010 Beats SHALL arrive in order from word 0; a beat counter SHALL wrap at SATIR_KELIME. After the last beat, the line and tag SHALL be written and the valid bit set.
REQ-011 In CEVAP, buyruk_hazir_o SHALL pulse with the requested word, unless the request was squashed.
REQ-012 iptal_i in any non-BOSTA state SHALL mark the request squashed: the fill completes and the line is installed, but no buyruk_hazir_o pulse is produced. iptal_i in the same cycle as a hit response SHALL suppress that pulse.
REQ-013 temizle_i SHALL clear all valid bits in one cycle when in BOSTA. When not in BOSTA, it SHALL be held pending and applied on return to BOSTA, including clearing the line just filled.
REQ-014 buyruk_hazir_o SHALL never be 1 for two consecutive cycles. buyruk_o SHALL hold its value between pulses.
REQ-015 New requests arriving while not in BOSTA SHALL be ignored. The fetch stage re-presents them.

Reset
REQ-016 Reset SHALL set: state BOSTA, all valid bits 0, beat counter 0, squash and pending-flush flags 0, buyruk_hazir_o 0, bellek_istek_o 0, buyruk_o 32'h0000_0013, bellek_adres_o 0.
REQ-017 Reset asserted mid-fill SHALL abandon the fill immediately with no line installed. Data and tag arrays are not reset.

Configuration
REQ-018 With BUYRUK_ONBELLEK_SAYAC_EN defined, the block SHALL add outputs isabet_sayisi_o[31:0] and iska_sayisi_o[31:0].
- Each counter increments once per accepted non-squashed hit or miss respectively.
- Each counter resets to 0 and wraps at 2^32.
REQ-019 Without BUYRUK_ONBELLEK_SAYAC_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding, the NOP constant 32'h0000_0013, and default line geometry constants.
REQ-021 The tag/valid/data storage SHALL be a sub-module buyruk_onbellek_dizisi with one read port and one line-write port. The FSM and fill buffer SHALL stay in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Cold miss at 0x0000_0100: expect bellek_adres_o=0x100; beats 0xA0..0xA3; buyruk_hazir_o pulses with 0xA0 in CEVAP.
- Re-request 0x0000_0104 after that fill: hit; 0xA1 exactly one cycle after acceptance; no bellek_istek_o.
- Conflict: 0x0000_0500 (same index, new tag): miss and refill. A following 0x100 misses again.
- iptal_i during DOLDUR beat 2: no buyruk_hazir_o pulse; the next 0x100 request hits.
- temizle_i during ISTEK: after return to BOSTA, 0x100 misses.
- rst_i low during beat 1 of a fill: outputs return to reset values asynchronously; the next 0x100 misses.
- With BUYRUK_ONBELLEK_SAYAC_EN defined: after the first three scenarios, isabet_sayisi_o=1 and iska_sayisi_o=3.
